usb_rx_pkt: RTL
===============

Name: usb_rx_pkt

Overview:
Packet decoder directly downstream of the USB low/full speed receiver, upstream of the SIE endpoint logic.
- Consumes the receiver's byte stream (data/active/valid/error).
- Validates PID, length and CRC5/CRC16.
- Emits decoded token fields, handshake PIDs, and a CRC-stripped data payload stream.
- Reports one end-of-packet status per received packet.

Parameters:
MAX_DATA, 64, maximum payload bytes in a DATA packet, excluding PID and CRC16; more sets len_err.

Ports:
clk  in  1  system clock (24 MHz)
reset  in  1  synchronous, active-high reset
rx_data  in  8  byte from receiver, LSB first on the wire; sampled when rx_valid=1
rx_active  in  1  high from SYNC end to EOP
rx_valid  in  1  one-cycle pulse per received byte
rx_error  in  1  one-cycle pulse, receiver error (stuffing/EOP)
pid  out  4  PID[3:0] of current/last packet
addr  out  7  token address
endp  out  4  token endpoint
frame  out  11  SOF frame number
tok_valid  out  1  pulse: OUT/IN/SETUP/SOF token accepted
hsk_valid  out  1  pulse: ACK/NAK/STALL accepted
dat_data  out  8  payload byte
dat_valid  out  1  pulse: dat_data valid
pkt_end  out  1  pulse: packet finished, status valid this cycle
pkt_ok  out  1  no error flag set (valid with pkt_end)
pid_err  out  1  PID check failed or PID unsupported
crc_err  out  1  CRC residual mismatch
len_err  out  1  wrong byte count for PID class
rx_err  out  1  rx_error seen during packet

Behaviour:
- Reset: all outputs 0, CRC registers preset, state WAIT_IDLE. Reset mid-packet discards the packet; no pkt_end for it.
- WAIT_IDLE: -> IDLE when rx_active=0; no report.
- IDLE: rx_active=1 -> PID.
- PID: first rx_valid byte b.
  - b[7:4] != ~b[3:0] -> pid_err, go DISCARD.
  - Otherwise latch pid=b[3:0] and dispatch:
    - OUT 0001, IN 1001, SETUP 1101, SOF 0101 -> TOKEN.
    - DATA0 0011, DATA1 1011 -> DATA.
    - ACK 0010, NAK 1010, STALL 1110 -> HSK.
    - Any other valid-check PID (PRE, DATA2, MDATA, ...) -> pid_err, DISCARD.
- TOKEN: accepts exactly 2 bytes (16 bits).
  - CRC5: poly x^5+x^2+1, init 11111, bits processed LSB-first across both bytes; required residual 01100.
  - Field layout: addr=bits[6:0], endp=bits[10:7]; for SOF, frame=bits[10:0].
  - Outputs are updated only for a good packet.
- DATA: every byte after PID feeds CRC16 (poly 0x8005, init 0xFFFF, LSB-first); required residual 0x800D.
  - Two-byte delay line: when a 3rd-or-later byte arrives, the oldest buffered byte is output on dat_data with dat_valid one cycle after rx_valid.
  - The final two bytes (CRC) are never forwarded.
  - Payload bytes go out before the CRC check; the consumer drops them when pkt_ok=0.
  - Payload count >MAX_DATA -> len_err; further forwarding stops.
- HSK: any byte after PID -> len_err.
- DISCARD: ignore bytes until rx_active=0.
- rx_error=1 in any non-idle state: set rx_err, go DISCARD.
- End of packet (rx_active 1->0 seen in PID/TOKEN/DATA/HSK/DISCARD):
  - Next cycle: pkt_end=1 for one cycle with error flags.
  - Same cycle: tok_valid or hsk_valid if pkt_ok and class matches.
  - Then -> IDLE.
- Length checks at end:
  - TOKEN byte count !=2 -> len_err.
  - DATA byte count <2 -> len_err.
  - Zero bytes total (PID never received) -> len_err, pid=0.
- Error flags are cleared at the start of each packet and hold until the next packet starts.
- Bytes while rx_active=0 are ignored. rx_active rising again in the pkt_end cycle starts a new packet normally.
- Flags are independent and may coexist (e.g. crc_err+len_err); pkt_ok = none set.

Test Plan:
1. Bytes 2D 00 10 -> tok_valid=1, pid=1101, addr=0, endp=0, pkt_end=1, pkt_ok=1.
2. Bytes 2D 00 11 -> pkt_end=1, crc_err=1, tok_valid=0, addr/endp unchanged.
3. Bytes C3 00 00 (DATA0 zero length) -> no dat_valid, pkt_ok=1. Then C3 11 22 33 + valid CRC16 -> dat_valid x3 with 11,22,33; CRC bytes not forwarded.
4. Byte D2 -> hsk_valid=1, pid=0010. Byte 2E -> pid_err=1, pkt_ok=0. D2 55 -> len_err=1, hsk_valid=0.
5. rx_error pulse mid DATA packet -> later bytes not forwarded, pkt_end with rx_err=1. DATA packet with 65 payload bytes -> len_err=1, dat_valid count = 64.
6. Reset asserted during TOKEN with rx_active held high -> no pkt_end for that packet. Next packet 2D 00 10 after rx_active low decodes with pkt_ok=1.

Source files
------------

// File: rtl/usb_rx_pkt.sv
// usb_rx_pkt: USB low/full-speed packet decoder.
// Takes the receiver byte stream, checks PID/length/CRC5/CRC16, publishes token
// fields and handshake PIDs, forwards DATA payload with the CRC16 stripped off,
// and reports exactly one end-of-packet status per packet.
module usb_rx_pkt #(
    parameter int MAX_DATA = 64
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [7:0]  rx_data,
    input  logic        rx_active,
    input  logic        rx_valid,
    input  logic        rx_error,
    output logic [3:0]  pid,
    output logic [6:0]  addr,
    output logic [3:0]  endp,
    output logic [10:0] frame,
    output logic        tok_valid,
    output logic        hsk_valid,
    output logic [7:0]  dat_data,
    output logic        dat_valid,
    output logic        pkt_end,
    output logic        pkt_ok,
    output logic        pid_err,
    output logic        crc_err,
    output logic        len_err,
    output logic        rx_err
);

    typedef enum logic [2:0] {
        S_WAIT_IDLE,
        S_IDLE,
        S_PID,
        S_TOKEN,
        S_DATA,
        S_HSK,
        S_DISCARD
    } state_t;

    typedef enum logic [1:0] {
        CLS_TOKEN,
        CLS_DATA,
        CLS_HSK,
        CLS_BAD
    } pid_class_t;

    // Byte counter covers the largest legal DATA packet plus the overflow byte,
    // and saturates so very long packets cannot wrap back into the legal range.
    localparam int              CNT_W   = $clog2(MAX_DATA + 3) + 1;
    localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);
    localparam logic [CNT_W-1:0] CNT_TWO = CNT_W'(2);
    localparam logic [CNT_W-1:0] CNT_OVF = CNT_W'(MAX_DATA + 2);
    localparam logic [CNT_W-1:0] CNT_SAT = '1;

    localparam logic [4:0]  CRC5_INIT      = 5'b11111;
    localparam logic [4:0]  CRC5_RESIDUAL  = 5'b01100;
    localparam logic [15:0] CRC16_INIT     = 16'hFFFF;
    localparam logic [15:0] CRC16_RESIDUAL = 16'h800D;
    localparam logic [3:0]  PID_SOF        = 4'b0101;

    // CRC5 (x^5+x^2+1) over one byte, wire order (LSB first).
    function automatic logic [4:0] crc5_byte(input logic [4:0] crc, input logic [7:0] data);
        logic [4:0] c;
        c = crc;
        for (int i = 0; i < 8; i++) begin
            if (data[i] ^ c[4]) c = {c[3:0], 1'b0} ^ 5'b00101;
            else                c = {c[3:0], 1'b0};
        end
        return c;
    endfunction

    // CRC16 (0x8005) over one byte, wire order (LSB first).
    function automatic logic [15:0] crc16_byte(input logic [15:0] crc, input logic [7:0] data);
        logic [15:0] c;
        c = crc;
        for (int i = 0; i < 8; i++) begin
            if (data[i] ^ c[15]) c = {c[14:0], 1'b0} ^ 16'h8005;
            else                 c = {c[14:0], 1'b0};
        end
        return c;
    endfunction

    function automatic pid_class_t classify(input logic [3:0] p);
        case (p)
            4'b0001, 4'b1001, 4'b1101, 4'b0101: return CLS_TOKEN;
            4'b0011, 4'b1011:                   return CLS_DATA;
            4'b0010, 4'b1010, 4'b1110:          return CLS_HSK;
            default:                            return CLS_BAD;
        endcase
    endfunction

    state_t           state, state_nxt;
    pid_class_t       cls;
    logic             pid_chk_ok;

    logic             in_pkt, start_pkt, end_pkt, err_evt, byte_evt;
    logic             pid_evt, tok_evt, dat_evt, hsk_evt;
    logic             end_len_err, end_crc_err, end_good;

    logic [4:0]       crc5;
    logic [15:0]      crc16;
    logic [CNT_W-1:0] byte_cnt;
    logic [7:0]       dly_old, dly_new;
    logic [10:0]      tok_bits;

    assign pid_chk_ok = (rx_data[7:4] == ~rx_data[3:0]);
    assign cls        = classify(rx_data[3:0]);

    // State register.
    always_ff @(posedge clk) begin
        if (reset) state <= S_WAIT_IDLE;
        else       state <= state_nxt;
    end

    // Next-state logic: end of packet wins over errors, errors win over bytes.
    always_comb begin
        // NOTE: every signal assigned in a combinational block gets a default
        // first, otherwise an unassigned path infers a latch.
        state_nxt = state;
        case (state)
            S_WAIT_IDLE: if (!rx_active) state_nxt = S_IDLE;
            S_IDLE:      if (rx_active)  state_nxt = S_PID;
            default: begin
                if (!rx_active) begin
                    state_nxt = S_IDLE;
                end else if (rx_error) begin
                    state_nxt = S_DISCARD;
                end else if (state == S_PID && rx_valid) begin
                    if (!pid_chk_ok) begin
                        state_nxt = S_DISCARD;
                    end else begin
                        case (cls)
                            CLS_TOKEN: state_nxt = S_TOKEN;
                            CLS_DATA:  state_nxt = S_DATA;
                            CLS_HSK:   state_nxt = S_HSK;
                            default:   state_nxt = S_DISCARD;
                        endcase
                    end
                end
            end
        endcase
    end

    // Output decode: per-cycle event strobes and the end-of-packet verdict.
    always_comb begin
        in_pkt      = (state == S_PID) || (state == S_TOKEN) || (state == S_DATA) ||
                      (state == S_HSK) || (state == S_DISCARD);
        start_pkt   = (state == S_IDLE) && rx_active;
        end_pkt     = in_pkt && !rx_active;
        err_evt     = in_pkt && rx_active && rx_error;
        byte_evt    = in_pkt && rx_active && rx_valid && !rx_error;
        pid_evt     = byte_evt && (state == S_PID);
        tok_evt     = byte_evt && (state == S_TOKEN);
        dat_evt     = byte_evt && (state == S_DATA);
        hsk_evt     = byte_evt && (state == S_HSK);

        end_len_err = 1'b0;
        end_crc_err = 1'b0;
        case (state)
            S_PID: end_len_err = 1'b1;
            S_TOKEN: begin
                end_len_err = (byte_cnt != CNT_TWO);
                end_crc_err = (byte_cnt >= CNT_TWO) && (crc5 != CRC5_RESIDUAL);
            end
            S_DATA: begin
                end_len_err = (byte_cnt < CNT_TWO);
                end_crc_err = (byte_cnt >= CNT_TWO) && (crc16 != CRC16_RESIDUAL);
            end
            default: ;
        endcase
        end_good = !(pid_err || crc_err || len_err || rx_err || end_len_err || end_crc_err);
    end

    // Datapath: CRCs, byte counting, payload delay line, field and status registers.
    always_ff @(posedge clk) begin
        // NOTE: state is updated with non-blocking assignments so every register
        // samples pre-edge values regardless of statement order.
        if (reset) begin
            pid       <= '0;
            addr      <= '0;
            endp      <= '0;
            frame     <= '0;
            tok_valid <= 1'b0;
            hsk_valid <= 1'b0;
            dat_data  <= '0;
            dat_valid <= 1'b0;
            pkt_end   <= 1'b0;
            pkt_ok    <= 1'b0;
            pid_err   <= 1'b0;
            crc_err   <= 1'b0;
            len_err   <= 1'b0;
            rx_err    <= 1'b0;
            crc5      <= CRC5_INIT;
            crc16     <= CRC16_INIT;
            byte_cnt  <= '0;
            dly_old   <= '0;
            dly_new   <= '0;
            tok_bits  <= '0;
        end else begin
            tok_valid <= 1'b0;
            hsk_valid <= 1'b0;
            dat_valid <= 1'b0;
            pkt_end   <= 1'b0;

            if (start_pkt) begin
                pkt_ok   <= 1'b0;
                pid_err  <= 1'b0;
                crc_err  <= 1'b0;
                len_err  <= 1'b0;
                rx_err   <= 1'b0;
                crc5     <= CRC5_INIT;
                crc16    <= CRC16_INIT;
                byte_cnt <= '0;
            end

            if (err_evt) rx_err <= 1'b1;

            if (pid_evt) begin
                if (!pid_chk_ok) begin
                    pid_err <= 1'b1;
                end else begin
                    pid <= rx_data[3:0];
                    if (cls == CLS_BAD) pid_err <= 1'b1;
                end
            end

            if (tok_evt) begin
                if (byte_cnt == '0)    tok_bits[7:0]  <= rx_data;
                if (byte_cnt == CNT_ONE) tok_bits[10:8] <= rx_data[2:0];
                if (byte_cnt < CNT_TWO)  crc5 <= crc5_byte(crc5, rx_data);
            end

            // Two-byte delay line keeps the trailing CRC16 from ever reaching the consumer.
            if (dat_evt) begin
                crc16   <= crc16_byte(crc16, rx_data);
                dly_old <= dly_new;
                dly_new <= rx_data;
                if (byte_cnt >= CNT_TWO && byte_cnt < CNT_OVF) begin
                    dat_data  <= dly_old;
                    dat_valid <= 1'b1;
                end
                if (byte_cnt == CNT_OVF) len_err <= 1'b1;
            end

            if (hsk_evt) len_err <= 1'b1;

            if ((tok_evt || dat_evt || hsk_evt) && byte_cnt != CNT_SAT)
                byte_cnt <= byte_cnt + CNT_ONE;

            if (end_pkt) begin
                pkt_end <= 1'b1;
                pkt_ok  <= end_good;
                if (end_len_err) len_err <= 1'b1;
                if (end_crc_err) crc_err <= 1'b1;
                if (state == S_PID) pid <= '0;
                if (end_good && state == S_TOKEN) begin
                    tok_valid <= 1'b1;
                    if (pid == PID_SOF) begin
                        frame <= tok_bits;
                    end else begin
                        addr <= tok_bits[6:0];
                        endp <= tok_bits[10:7];
                    end
                end
                if (end_good && state == S_HSK) hsk_valid <= 1'b1;
            end
        end
    end

endmodule
